// File: rtl/tff_counter_n_if.sv
// Bus bundle for tff_counter_n: the controller drives enable, direction and load,
// and the counter returns its value and flags.
interface tff_counter_n_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output en,
        output up,
        output load,
        output din,
        input  q,
        input  tc,
        input  ovf
    );

    modport slave (
        input  en,
        input  up,
        input  load,
        input  din,
        output q,
        output tc,
        output ovf
    );

endinterface : tff_counter_n_if

// File: rtl/tff_counter_n.sv
// WIDTH-bit up/down counter built from a chain of T-type stages.
// The natural T chain gives q+1 / q-1 everywhere except at the range ends.
// At the range ends the next value is overridden by the wrap or saturate rule.
// Loads are clamped to MAX_VAL, and ovf latches every boundary crossing until the
// next load or reset. tc is combinational so that tc can drive a cascaded stage's
// en with no extra latency.
module tff_counter_n #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    tff_counter_n_if.slave   bus
);

    localparam longint unsigned SPAN  = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};

    // A zero modulus or one that does not fit in WIDTH bits cannot be built.
    generate
        if ((WIDTH == 0) || (MAX_VAL == 0) || (64'(MAX_VAL) >= SPAN)) begin : g_bad_cfg
            $error("tff_counter_n: MAX_VAL=%0d is out of range for WIDTH=%0d", MAX_VAL, WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] t_s;
    logic             up_chain_s;
    logic             dn_chain_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic [WIDTH-1:0] load_val_s;

    assign at_max_s   = (q_q == MAX_Q);
    assign at_zero_s  = (q_q == ZERO_Q);
    assign load_val_s = (bus.din > MAX_Q) ? MAX_Q : bus.din;

    // T inputs: a stage toggles when every lower stage is 1 (up) or 0 (down).
    always_comb begin
        t_s        = {WIDTH{1'b0}};
        up_chain_s = 1'b1;
        dn_chain_s = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            t_s[i]     = bus.en & (bus.up ? up_chain_s : dn_chain_s);
            up_chain_s = up_chain_s & q_q[i];
            dn_chain_s = dn_chain_s & ~q_q[i];
        end
    end

    // Next state: load beats enable; boundary steps override the T chain.
    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (bus.load) begin
            q_d   = load_val_s;
            ovf_d = 1'b0;
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max_s) begin
                    q_d   = (SATURATE != 0) ? q_q : ZERO_Q;
                    ovf_d = 1'b1;
                end else begin
                    q_d   = q_q ^ t_s;
                    ovf_d = ovf_q;
                end
            end else begin
                if (at_zero_s) begin
                    q_d   = (SATURATE != 0) ? q_q : MAX_Q;
                    ovf_d = 1'b1;
                end else begin
                    q_d   = q_q ^ t_s;
                    ovf_d = ovf_q;
                end
            end
        end else begin
            q_d   = q_q;
            ovf_d = ovf_q;
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= ZERO_Q;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.q   = q_q;
    assign bus.ovf = ovf_q;
    assign bus.tc  = bus.en & ~bus.load & (bus.up ? at_max_s : at_zero_s);

endmodule : tff_counter_n

// File: tb/tb_tff_counter_n.sv
// Bench for tff_counter_n: wrap (4-bit, mod 10), saturate (4-bit, mod 10) and
// legacy 1-bit toggle instances share clock and reset.
`timescale 1ns/1ps
module tb_tff_counter_n;

    logic clk = 1'b0;
    logic rst;

    always #2 clk = ~clk;

    tff_counter_n_if #(.WIDTH(4)) bw ();
    tff_counter_n_if #(.WIDTH(4)) bs ();
    tff_counter_n_if #(.WIDTH(1)) bl ();

    tff_counter_n #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_wrap (.clk(clk), .rst(rst), .bus(bw.slave));
    tff_counter_n #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_sat  (.clk(clk), .rst(rst), .bus(bs.slave));
    tff_counter_n #(.WIDTH(1), .MAX_VAL(1), .SATURATE(0)) u_leg  (.clk(clk), .rst(rst), .bus(bl.slave));

    typedef struct {
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] din;
        logic       exp_tc;
        logic [3:0] exp_q;
        logic       exp_ovf;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t mk(input logic en, input logic up, input logic load,
                                input logic [3:0] din, input logic tc,
                                input logic [3:0] q, input logic ovf);
        vec_t v;
        v.en = en; v.up = up; v.load = load; v.din = din;
        v.exp_tc = tc; v.exp_q = q; v.exp_ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] q_of(input int sel);
        case (sel)
            0:       return bw.q;
            1:       return bs.q;
            default: return {3'b000, bl.q};
        endcase
    endfunction

    function automatic logic tc_of(input int sel);
        case (sel)
            0:       return bw.tc;
            1:       return bs.tc;
            default: return bl.tc;
        endcase
    endfunction

    function automatic logic ovf_of(input int sel);
        case (sel)
            0:       return bw.ovf;
            1:       return bs.ovf;
            default: return bl.ovf;
        endcase
    endfunction

    task automatic idle_all();
        bw.en = 1'b0; bw.up = 1'b1; bw.load = 1'b0; bw.din = 4'd0;
        bs.en = 1'b0; bs.up = 1'b1; bs.load = 1'b0; bs.din = 4'd0;
        bl.en = 1'b0; bl.up = 1'b1; bl.load = 1'b0; bl.din = 1'b0;
    endtask

    // One edge on one instance: check tc before the edge, q/ovf after it.
    task automatic apply(input int sel, input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        idle_all();
        case (sel)
            0: begin bw.en = v.en; bw.up = v.up; bw.load = v.load; bw.din = v.din; end
            1: begin bs.en = v.en; bs.up = v.up; bs.load = v.load; bs.din = v.din; end
            default: begin bl.en = v.en; bl.up = v.up; bl.load = v.load; bl.din = v.din[0]; end
        endcase
        #1;
        check({tag, ".tc"}, {7'd0, tc_of(sel)}, {7'd0, v.exp_tc});
        e.q = v.exp_q; e.ovf = v.exp_ovf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL %s.sb: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".q"},   {4'd0, q_of(sel)},   {4'd0, e.q});
            check({tag, ".ovf"}, {7'd0, ovf_of(sel)}, {7'd0, e.ovf});
        end
    endtask

    task automatic full_reset();
        @(negedge clk);
        idle_all();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst%0d.q", s),   {4'd0, q_of(s)},   8'd0);
            check($sformatf("rst%0d.ovf", s), {7'd0, ovf_of(s)}, 8'd0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        idle_all();
        rst = 1'b0;

        // 1. Reset, count to 5, asynchronous pulse mid-count, resume from 0.
        full_reset();
        for (int i = 1; i <= 5; i++)
            apply(0, mk(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'(i), 1'b0), $sformatf("cnt%0d", i));
        @(negedge clk);
        bw.en = 1'b1; bw.up = 1'b1;
        #0.5;
        rst = 1'b0;
        #0.5;
        check("async.q",   {4'd0, bw.q},   8'd0);
        check("async.ovf", {7'd0, bw.ovf}, 8'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("resume.q", {4'd0, bw.q}, 8'd1);
        full_reset();

        // Wrap-instance vectors.
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, (i == 9),
                             4'((i + 1) % 10), (i >= 9)));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 4'd6,  1'b0, 4'd6, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 4'd14, 1'b0, 4'd9, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd8, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd7, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 4'd4, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd4, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd4, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd4, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd4, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd4, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd9, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0, 1'b1));

        for (int i = 0; i < tbl.size(); i++)
            apply(0, tbl[i], $sformatf("wrap[%0d]", i));

        // 3. Saturate instance: hold at 0 going down, climb to 9 and hold there.
        apply(1, mk(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1), "sat.dn0");
        apply(1, mk(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1), "sat.dn1");
        for (int i = 1; i <= 9; i++)
            apply(1, mk(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'(i), 1'b1), $sformatf("sat.up%0d", i));
        apply(1, mk(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd9, 1'b1), "sat.hold9");
        apply(1, mk(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0), "sat.load3");

        // 6. Legacy 1-bit toggle after a fresh reset.
        full_reset();
        for (int i = 0; i < 8; i++)
            apply(2, mk(1'b1, 1'b1, 1'b0, 4'd0, (i % 2 == 1), 4'((i + 1) % 2), (i >= 1)),
                  $sformatf("leg%0d", i));
        apply(2, mk(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1), "leg.one");
        apply(2, mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1), "leg.frz0");
        apply(2, mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1), "leg.frz1");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_tff_counter_n
